pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: PC and target width in bits.
REQ-002 Parameter NRED, default 3: number of redirect channels.
REQ-003 Parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-004 Parameter INST_BYTES, default 4, power of two: sequential PC step.
REQ-005 Parameter EPOCH_W, default 2: redirect epoch counter width.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 stall  input  2  pipeline control: 00 Pass, 01 Hold, 10 Bubble, 11 treated as Hold.
REQ-009 redir_valid  input  NRED  per-channel redirect request; bit 0 highest priority.
REQ-010 redir_target  input  NRED*XLEN  channel i target at bits [i*XLEN +: XLEN].
REQ-011 fetch_ready  input  1  fetch stage accepts the current PC this cycle.
REQ-012 pc_o  output  XLEN  current fetch PC, registered.
REQ-013 pc_valid  output  1  pc_o is a valid fetch request, registered.
REQ-014 epoch_o  output  EPOCH_W  redirect epoch tag, registered.
REQ-015 redir_pending  output  1  a redirect is latched and not yet applied, registered.

Function
REQ-016 fire = pc_valid AND fetch_ready AND stall==Pass; on fire without a redirect, pc_o SHALL become pc_o + INST_BYTES modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 at defaults).
REQ-017 Redirect selection SHALL be combinational: lowest-index asserted redir_valid bit wins; others that cycle are dropped.
REQ-018 Selected target SHALL have its low log2(INST_BYTES) bits forced to zero before use.
REQ-019 Redirect in a Pass cycle: pc_o <= target next edge, pc_valid <= 1, epoch_o increments, pending cleared; applies regardless of fetch_ready and overrides the sequential increment.
REQ-020 Redirect in a Hold or Bubble cycle: target SHALL be stored in the pending register, redir_pending <= 1; pc_o, epoch_o unchanged that cycle.
REQ-021 A new redirect while pending is set and stall!=Pass SHALL overwrite the pending target (newest wins).
REQ-022 First Pass cycle with pending set and no live redirect: pc_o <= pending target, pc_valid <= 1, epoch_o increments once, redir_pending <= 0.
REQ-023 Pass cycle with pending set and a live redirect: live target wins, pending discarded, epoch_o increments once.
REQ-024 Hold with no redirect: pc_o, pc_valid, epoch_o, pending all unchanged.
REQ-025 Bubble: pc_valid <= 0, pc_o retained (not zeroed), epoch_o unchanged.
REQ-026 Pass with pc_valid==0 and no redirect/pending: pc_valid <= 1, pc_o unchanged (re-issue retained PC, no increment).
REQ-027 Pass with pc_valid==1, fetch_ready==0, no redirect/pending: all state unchanged.
REQ-028 epoch_o SHALL wrap from 2^EPOCH_W-1 to 0.
REQ-029 Latency: every redirect or increment visible on outputs exactly one clock after the deciding edge; no combinational input-to-output path.

Reset
REQ-030 rst high at an edge SHALL set pc_o=RESET_VEC, pc_valid=1, epoch_o=0, redir_pending=0, pending target=0, overriding stall, redirects and fetch_ready that cycle.
REQ-031 rst asserted mid-operation SHALL discard any pending redirect; first post-reset Pass fire yields RESET_VEC+INST_BYTES.

Verification
REQ-032 Reset, stall=Pass, fetch_ready=1 for 3 cycles -> pc_o 0x0, 0x4, 0x8, 0xC; epoch_o=0.
REQ-033 pc_o=0x10, redir_valid=3'b110 with targets ch1=0x100, ch2=0x200 in Pass -> pc_o=0x100, epoch_o=1.
REQ-034 stall=Hold, redirect ch2 to 0x203 -> redir_pending=1, pc_o unchanged; next cycle Pass -> pc_o=0x200, epoch_o+1, redir_pending=0.
REQ-035 pc_o=0x40, stall=Bubble one cycle -> pc_valid=0, pc_o=0x40; then Pass, fetch_ready=1 -> pc_valid=1, pc_o=0x40, then 0x44.
REQ-036 Four Pass redirects from epoch 0 -> epoch_o 1,2,3,0; pc_o=0xFFFFFFFC with fire -> 0x0.
REQ-037 Pending set to 0x300, rst asserted one cycle -> pc_o=0x0, redir_pending=0, epoch_o=0; 0x300 never appears.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential stepping, prioritised redirects with epoch
// tagging, and a one-deep pending slot that holds a redirect across stalls.
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter int              NRED       = 3,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              INST_BYTES = 4,
    parameter int              EPOCH_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           stall,
    input  logic [NRED-1:0]      redir_valid,
    input  logic [NRED*XLEN-1:0] redir_target,
    input  logic                 fetch_ready,
    output logic [XLEN-1:0]      pc_o,
    output logic                 pc_valid,
    output logic [EPOCH_W-1:0]   epoch_o,
    output logic                 redir_pending
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);

    logic [XLEN-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               pend_q, pend_d;
    logic [XLEN-1:0]    pend_tgt_q, pend_tgt_d;

    logic               sel_valid;
    logic [XLEN-1:0]    sel_target;
    logic               is_pass, is_bubble;

    assign is_pass   = (stall == 2'b00);
    assign is_bubble = (stall == 2'b10);

    // Walk from the highest index down so the lowest asserted channel wins.
    always_comb begin
        sel_valid  = 1'b0;
        sel_target = '0;
        for (int i = NRED - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                sel_valid  = 1'b1;
                sel_target = redir_target[i*XLEN +: XLEN] & ALIGN_MASK;
            end
        end
    end

    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        epoch_d    = epoch_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (is_pass) begin
            if (sel_valid) begin
                pc_d    = sel_target;
                valid_d = 1'b1;
                epoch_d = epoch_q + EPOCH_W'(1);
                pend_d  = 1'b0;
            end else if (pend_q) begin
                pc_d    = pend_tgt_q;
                valid_d = 1'b1;
                epoch_d = epoch_q + EPOCH_W'(1);
                pend_d  = 1'b0;
            end else if (!valid_q) begin
                // Re-issue the retained PC after a bubble.
                valid_d = 1'b1;
            end else if (fetch_ready) begin
                pc_d = pc_q + STEP;
            end
        end else begin
            if (sel_valid) begin
                pend_d     = 1'b1;
                pend_tgt_d = sel_target;
            end
            if (is_bubble) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b1;
            epoch_q    <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            epoch_q    <= epoch_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc_o          = pc_q;
    assign pc_valid      = valid_q;
    assign epoch_o       = epoch_q;
    assign redir_pending = pend_q;

endmodule
